// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/sequencing controller: load-use stalls, redirect flushes, memory-wait holds
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_redirect,
  input  logic [31:0]      i_ex_target,
  input  logic             i_mem_busy,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_stall,
  output logic             o_pc_redirect,
  output logic [31:0]      o_pc_target,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0]    FONE = FW'(1);
  localparam logic [FW-1:0]    FLOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  state_t         r_state;
  logic [FW-1:0]  r_fcnt;
  logic           r_pend_valid;
  logic [31:0]    r_pend_target;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t         w_state_nxt;
  logic [FW-1:0]  w_fcnt_nxt;
  logic           w_pend_valid_nxt;
  logic [31:0]    w_pend_target_nxt;
  logic           w_load_use;
  logic           w_pc_stall;
  logic           w_if_id_stall;
  logic           w_if_id_flush;
  logic           w_id_ex_flush;
  logic           w_ex_mem_stall;
  logic           w_pc_redirect;
  logic [31:0]    w_pc_target;

  assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                      ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

  always_comb begin
    w_state_nxt       = r_state;
    w_fcnt_nxt        = r_fcnt;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    w_pc_stall        = 1'b0;
    w_if_id_stall     = 1'b0;
    w_if_id_flush     = 1'b0;
    w_id_ex_flush     = 1'b0;
    w_ex_mem_stall    = 1'b0;
    w_pc_redirect     = 1'b0;
    w_pc_target       = 32'd0;
    if (i_mem_busy) begin
      // Whole pipe holds; a redirect seen now is parked until the wait ends.
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_state_nxt    = ST_MWAIT;
      if (i_ex_redirect) begin
        w_pend_valid_nxt  = 1'b1;
        w_pend_target_nxt = i_ex_target;
      end
    end else if (i_ex_redirect || r_pend_valid) begin
      w_pc_redirect    = 1'b1;
      w_if_id_flush    = 1'b1;
      w_id_ex_flush    = 1'b1;
      w_pc_target      = r_pend_valid ? r_pend_target : i_ex_target;
      w_pend_valid_nxt = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        w_fcnt_nxt  = FLOAD;
        w_state_nxt = ST_FLUSH;
      end else begin
        w_fcnt_nxt  = '0;
        w_state_nxt = ST_RUN;
      end
    end else if ((r_state != ST_RUN) && (r_fcnt != '0)) begin
      // Also resumes a flush window that a memory wait froze.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_fcnt_nxt    = r_fcnt - FONE;
      w_state_nxt   = (r_fcnt == FONE) ? ST_RUN : ST_FLUSH;
    end else begin
      w_state_nxt = ST_RUN;
      if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_RUN;
      r_fcnt        <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
      if (w_pc_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CONE;
      if (w_pc_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CONE;
    end
  end

  assign o_pc_stall     = rstn & w_pc_stall;
  assign o_if_id_stall  = rstn & w_if_id_stall;
  assign o_if_id_flush  = rstn & w_if_id_flush;
  assign o_id_ex_flush  = rstn & w_id_ex_flush;
  assign o_ex_mem_stall = rstn & w_ex_mem_stall;
  assign o_pc_redirect  = rstn & w_pc_redirect;
  assign o_pc_target    = rstn ? w_pc_target : 32'd0;
  assign o_ctrl_state   = r_state;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_busy;
  logic [31:0] ex_target;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, pc_redirect;
  logic [31:0] pc_target;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
    .i_ex_redirect(ex_redirect), .i_ex_target(ex_target),
    .i_mem_busy(mem_busy),
    .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_stall(ex_mem_stall), .o_pc_redirect(pc_redirect),
    .o_pc_target(pc_target), .o_ctrl_state(ctrl_state),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       e_stall;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_read = 0; ex_rd = 0; ex_redirect = 0; ex_target = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1;
  endtask

  initial begin
    int exp_cnt;
    vecs[0] = '{5'd0,  5'd5, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1};
    vecs[1] = '{5'd0,  5'd0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0};
    vecs[2] = '{5'd0,  5'd5, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0};
    vecs[3] = '{5'd7,  5'd0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b1};
    vecs[4] = '{5'd7,  5'd0, 1'b1, 1'b0, 1'b0, 5'd7,  1'b0};
    vecs[5] = '{5'd3,  5'd4, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0};
    vecs[6] = '{5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b1};

    rstn = 0;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", ctrl_state, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_pc_stall", pc_stall, 0);
    rstn = 1;
    tick();

    // load-use table in RUN
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2;
      ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_pc_stall", i), pc_stall, vecs[i].e_stall);
      chk($sformatf("v%0d_if_id_stall", i), if_id_stall, vecs[i].e_stall);
      chk($sformatf("v%0d_id_ex_flush", i), id_ex_flush, vecs[i].e_stall);
      chk($sformatf("v%0d_if_id_flush", i), if_id_flush, 0);
      chk($sformatf("v%0d_ex_mem_stall", i), ex_mem_stall, 0);
      chk($sformatf("v%0d_pc_redirect", i), pc_redirect, 0);
      tick();
      if (vecs[i].e_stall) exp_cnt++;
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, exp_cnt);
      chk($sformatf("v%0d_state", i), ctrl_state, 0);
    end

    // redirect, two-cycle flush, load-use ignored during FLUSH
    clr();
    ex_redirect = 1; ex_target = 32'h100;
    @(negedge clk);
    chk("rd_pc_redirect", pc_redirect, 1);
    chk("rd_pc_target", pc_target, 32'h100);
    chk("rd_if_id_flush", if_id_flush, 1);
    chk("rd_id_ex_flush", id_ex_flush, 1);
    chk("rd_pc_stall", pc_stall, 0);
    tick();
    clr();
    set_load_use();
    @(negedge clk);
    chk("fl_state", ctrl_state, 1);
    chk("fl_if_id_flush", if_id_flush, 1);
    chk("fl_pc_redirect", pc_redirect, 0);
    chk("fl_pc_stall_ignored", pc_stall, 0);
    tick();
    clr();
    @(negedge clk);
    chk("fl_done_state", ctrl_state, 0);
    chk("fl_done_flush", if_id_flush, 0);
    chk("fl_flush_cnt", flush_cnt, 1);
    tick();

    // load-use and redirect together
    set_load_use();
    ex_redirect = 1; ex_target = 32'h180;
    @(negedge clk);
    chk("lr_pc_stall", pc_stall, 0);
    chk("lr_if_id_stall", if_id_stall, 0);
    chk("lr_pc_redirect", pc_redirect, 1);
    chk("lr_pc_target", pc_target, 32'h180);
    tick();
    clr();
    tick();

    // memory wait with redirect parked
    mem_busy = 1; ex_redirect = 1; ex_target = 32'h200;
    @(negedge clk);
    chk("mw1_pc_stall", pc_stall, 1);
    chk("mw1_if_id_stall", if_id_stall, 1);
    chk("mw1_ex_mem_stall", ex_mem_stall, 1);
    chk("mw1_if_id_flush", if_id_flush, 0);
    chk("mw1_pc_redirect", pc_redirect, 0);
    tick();
    ex_redirect = 0; ex_target = 0;
    @(negedge clk);
    chk("mw2_state", ctrl_state, 2);
    chk("mw2_pc_stall", pc_stall, 1);
    tick();
    @(negedge clk);
    chk("mw3_pc_stall", pc_stall, 1);
    tick();
    mem_busy = 0;
    @(negedge clk);
    chk("mw4_pc_redirect", pc_redirect, 1);
    chk("mw4_pc_target", pc_target, 32'h200);
    chk("mw4_if_id_flush", if_id_flush, 1);
    chk("mw4_pc_stall", pc_stall, 0);
    tick();
    chk("mw5_state", ctrl_state, 1);
    tick();
    chk("mw6_state", ctrl_state, 0);

    // a later redirect during the wait overwrites the parked target
    mem_busy = 1; ex_redirect = 1; ex_target = 32'h400;
    tick();
    ex_target = 32'h440;
    tick();
    clr();
    @(negedge clk);
    chk("ow_pc_redirect", pc_redirect, 1);
    chk("ow_pc_target", pc_target, 32'h440);
    tick();
    tick();

    // busy with load-use: stall only, no bubble
    mem_busy = 1;
    set_load_use();
    @(negedge clk);
    chk("bl_pc_stall", pc_stall, 1);
    chk("bl_id_ex_flush", id_ex_flush, 0);
    chk("bl_if_id_flush", if_id_flush, 0);
    tick();
    clr();
    @(negedge clk);
    chk("bl_exit_pc_stall", pc_stall, 0);
    chk("bl_exit_redirect", pc_redirect, 0);
    tick();
    chk("bl_state", ctrl_state, 0);

    // busy arriving mid-flush freezes then resumes the flush window
    ex_redirect = 1; ex_target = 32'h500;
    tick();
    clr();
    mem_busy = 1;
    @(negedge clk);
    chk("fz_if_id_flush", if_id_flush, 0);
    chk("fz_pc_stall", pc_stall, 1);
    tick();
    mem_busy = 0;
    @(negedge clk);
    chk("fz_state", ctrl_state, 2);
    chk("fz_resume_flush", if_id_flush, 1);
    chk("fz_resume_redirect", pc_redirect, 0);
    tick();
    @(negedge clk);
    chk("fz_done_state", ctrl_state, 0);
    chk("fz_done_flush", if_id_flush, 0);
    chk("fz_flush_cnt", flush_cnt, 5);
    tick();

    // async reset while a redirect is parked
    mem_busy = 1; ex_redirect = 1; ex_target = 32'h600;
    tick();
    clr();
    #1;
    rstn = 0;
    #1;
    chk("ar_pc_redirect", pc_redirect, 0);
    chk("ar_pc_target", pc_target, 0);
    chk("ar_if_id_flush", if_id_flush, 0);
    chk("ar_state", ctrl_state, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rstn = 1;
    tick();
    @(negedge clk);
    chk("ar_after_redirect", pc_redirect, 0);
    chk("ar_after_state", ctrl_state, 0);
    chk("ar_after_flush_cnt", flush_cnt, 0);
    tick();

    // stall counter saturation
    mem_busy = 1;
    repeat (300) tick();
    chk("sat_stall_cnt", stall_cnt, 255);
    chk("sat_state", ctrl_state, 2);
    clr();
    tick();
    chk("sat_hold", stall_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
